// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - fetch stage control, instruction memory and IF/ID bundle
interface fetch_stage_if;
   logic        stall;
   logic        flush;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        resume;
   logic [31:0] PC;
   logic [31:0] Instr;
   logic        if_id_valid;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_pc_plus4;
   logic [31:0] if_id_instr;
   logic        misalign_err;
   logic        halted;

   modport master (
      input  stall, flush, redirect_valid, redirect_pc, resume, Instr,
      output PC, if_id_valid, if_id_pc, if_id_pc_plus4, if_id_instr, misalign_err, halted
   );

   modport slave (
      output stall, flush, redirect_valid, redirect_pc, resume, Instr,
      input  PC, if_id_valid, if_id_pc, if_id_pc_plus4, if_id_instr, misalign_err, halted
   );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC owner and IF/ID register with stall/flush/redirect and EBREAK halt
// Optional FETCH_PERF_CNT_EN adds saturating fetch/stall/halt counters.
module fetch_stage #(
   parameter logic [31:0] RESET_PC       = 32'h0000_0000,
   parameter bit          HALT_ON_EBREAK = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   fetch_stage_if.master     bus
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]       fetch_count,
   output logic [31:0]       stall_count,
   output logic [15:0]       halt_count
`endif
);

   localparam logic [31:0] NOP    = 32'h0000_0013;
   localparam logic [31:0] EBREAK = 32'h0010_0073;

   typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

   state_t      state, state_n;
   logic [31:0] pc, pc_n;
   logic        valid, valid_n;
   logic [31:0] ipc, ipc_n;
   logic [31:0] ipc4, ipc4_n;
   logic [31:0] instr, instr_n;
   logic        mis, mis_n;
   logic        cap;
   logic [31:0] pc_plus4;
   logic [31:0] redir_pc;

   assign pc_plus4 = pc + 32'd4;
   assign redir_pc = {bus.redirect_pc[31:2], 2'b00};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= BOOT;
         pc    <= RESET_PC;
         valid <= 1'b0;
         ipc   <= 32'h0;
         ipc4  <= 32'h0;
         instr <= NOP;
         mis   <= 1'b0;
      end else begin
         state <= state_n;
         pc    <= pc_n;
         valid <= valid_n;
         ipc   <= ipc_n;
         ipc4  <= ipc4_n;
         instr <= instr_n;
         mis   <= mis_n;
      end
   end

   always_comb begin
      state_n = state;
      pc_n    = pc;
      valid_n = valid;
      ipc_n   = ipc;
      ipc4_n  = ipc4;
      instr_n = instr;
      mis_n   = 1'b0;
      cap     = 1'b0;
      case (state)
         BOOT: state_n = RUN;
         RUN: begin
            if (bus.redirect_valid) begin
               pc_n    = redir_pc;
               valid_n = 1'b0; ipc_n = 32'h0; ipc4_n = 32'h0; instr_n = NOP;
               mis_n   = |bus.redirect_pc[1:0];
            end else if (bus.flush) begin
               valid_n = 1'b0; ipc_n = 32'h0; ipc4_n = 32'h0; instr_n = NOP;
               if (!bus.stall) pc_n = pc_plus4;
            end else if (!bus.stall) begin
               cap     = 1'b1;
               valid_n = 1'b1;
               ipc_n   = pc;
               ipc4_n  = pc_plus4;
               instr_n = bus.Instr;
               // EBREAK is delivered to decode but the PC parks on it
               if (HALT_ON_EBREAK && bus.Instr == EBREAK) state_n = HALT;
               else                                       pc_n    = pc_plus4;
            end
         end
         HALT: begin
            valid_n = 1'b0; ipc_n = 32'h0; ipc4_n = 32'h0; instr_n = NOP;
            if (bus.redirect_valid) begin
               pc_n  = redir_pc;
               mis_n = |bus.redirect_pc[1:0];
            end else if (bus.resume) begin
               pc_n    = pc_plus4;
               state_n = RUN;
            end
         end
         default: state_n = BOOT;
      endcase
   end

   assign bus.PC             = pc;
   assign bus.if_id_valid    = valid;
   assign bus.if_id_pc       = ipc;
   assign bus.if_id_pc_plus4 = ipc4;
   assign bus.if_id_instr    = instr;
   assign bus.misalign_err   = mis;
   assign bus.halted         = (state == HALT);

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_count <= 32'h0;
         stall_count <= 32'h0;
         halt_count  <= 16'h0;
      end else begin
         if (cap && fetch_count != 32'hFFFF_FFFF) fetch_count <= fetch_count + 32'd1;
         if (state == RUN && bus.stall && !bus.redirect_valid && stall_count != 32'hFFFF_FFFF)
            stall_count <= stall_count + 32'd1;
         if (state == RUN && state_n == HALT && halt_count != 16'hFFFF)
            halt_count <= halt_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage
module tb_fetch_stage;
   localparam logic [31:0] NOP    = 32'h0000_0013;
   localparam logic [31:0] EBREAK = 32'h0010_0073;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   fetch_stage_if bus ();

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_count, stall_count;
   logic [15:0] halt_count;
`endif

   fetch_stage #(.RESET_PC(32'h0), .HALT_ON_EBREAK(1'b1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
`ifdef FETCH_PERF_CNT_EN
      ,
      .fetch_count (fetch_count),
      .stall_count (stall_count),
      .halt_count  (halt_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_model(input logic [31:0] a);
      if (a == 32'h10) return EBREAK;
      return {a[31:2], 2'b11};
   endfunction

   always_comb bus.Instr = mem_model(bus.PC);

   logic [31:0] exp_pc;
   logic        exp_valid;
   logic        exp_halt;
   logic        exp_mis;
   logic [63:0] sb_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // drive one cycle of inputs from a negedge, advance the reference, compare at next negedge
   task automatic step(input logic st, input logic fl, input logic rv,
                       input logic [31:0] rpc, input logic rs);
      logic        cap;
      logic [63:0] e;
      cap = 1'b0;
      bus.stall = st; bus.flush = fl; bus.redirect_valid = rv;
      bus.redirect_pc = rpc; bus.resume = rs;
      exp_mis = 1'b0;
      if (!exp_halt) begin
         if (rv) begin
            exp_pc = {rpc[31:2], 2'b00}; exp_valid = 1'b0; exp_mis = |rpc[1:0];
         end else if (fl) begin
            exp_valid = 1'b0;
            if (!st) exp_pc = exp_pc + 32'd4;
         end else if (!st) begin
            cap = 1'b1;
            exp_valid = 1'b1;
            sb_q.push_back({exp_pc, mem_model(exp_pc)});
            if (mem_model(exp_pc) == EBREAK) exp_halt = 1'b1;
            else                             exp_pc   = exp_pc + 32'd4;
         end
      end else begin
         exp_valid = 1'b0;
         if (rv) begin
            exp_pc = {rpc[31:2], 2'b00}; exp_mis = |rpc[1:0];
         end else if (rs) begin
            exp_pc = exp_pc + 32'd4; exp_halt = 1'b0;
         end
      end
      @(posedge clk);
      @(negedge clk);
      check("pc", bus.PC, exp_pc);
      check("valid", 32'(bus.if_id_valid), 32'(exp_valid));
      check("halted", 32'(bus.halted), 32'(exp_halt));
      check("misalign", 32'(bus.misalign_err), 32'(exp_mis));
      if (!exp_valid) check("bubble_nop", bus.if_id_instr, NOP);
      if (cap) begin
         if (sb_q.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
         end else begin
            e = sb_q.pop_front();
            check("sb_pc", bus.if_id_pc, e[63:32]);
            check("sb_pc4", bus.if_id_pc_plus4, e[63:32] + 32'd4);
            check("sb_instr", bus.if_id_instr, e[31:0]);
         end
      end
   endtask

   initial begin
      n_checks = 0; n_errors = 0;
      rst_n = 1'b0;
      bus.stall = 1'b0; bus.flush = 1'b0; bus.redirect_valid = 1'b0;
      bus.redirect_pc = 32'h0; bus.resume = 1'b0;
      exp_pc = 32'h0; exp_valid = 1'b0; exp_halt = 1'b0; exp_mis = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_pc", bus.PC, 32'h0);
      check("rst_valid", 32'(bus.if_id_valid), 32'd0);
      check("rst_instr", bus.if_id_instr, NOP);
      check("rst_pc_id", bus.if_id_pc, 32'h0);
      check("rst_halted", 32'(bus.halted), 32'd0);
      check("rst_mis", 32'(bus.misalign_err), 32'd0);

      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("boot_pc", bus.PC, 32'h0);
      check("boot_valid", 32'(bus.if_id_valid), 32'd0);

      step(0, 0, 0, 32'h0, 0);
      check("c2_pc", bus.PC, 32'h4);
      check("c2_instr", bus.if_id_instr, 32'h0000_0003);
      step(0, 0, 0, 32'h0, 0);
      check("c3_pc_id", bus.if_id_pc, 32'h4);
      check("c3_pc4", bus.if_id_pc_plus4, 32'h8);

      for (int i = 0; i < 3; i++) begin
         step(1, 0, 0, 32'h0, 0);
         check("stall_pc", bus.PC, 32'h8);
         check("stall_pc_id", bus.if_id_pc, 32'h4);
      end
      step(0, 0, 0, 32'h0, 0);
      check("unstall_pc_id", bus.if_id_pc, 32'h8);

      step(1, 0, 1, 32'h40, 0);
      check("redir_pc", bus.PC, 32'h40);
      check("redir_valid", 32'(bus.if_id_valid), 32'd0);
      step(0, 0, 0, 32'h0, 0);
      check("redir_pc_id", bus.if_id_pc, 32'h40);

      step(0, 0, 1, 32'h46, 0);
      check("mis_pc", bus.PC, 32'h44);
      check("mis_pulse", 32'(bus.misalign_err), 32'd1);
      step(0, 0, 0, 32'h0, 0);
      check("mis_clear", 32'(bus.misalign_err), 32'd0);

      step(0, 1, 0, 32'h0, 0);
      step(1, 1, 0, 32'h0, 0);
      check("stall_flush_valid", 32'(bus.if_id_valid), 32'd0);

      step(0, 0, 1, 32'h10, 0);
      step(0, 0, 0, 32'h0, 0);
      check("ebreak_instr", bus.if_id_instr, EBREAK);
      check("ebreak_valid", 32'(bus.if_id_valid), 32'd1);
      check("ebreak_halted", 32'(bus.halted), 32'd1);
      check("ebreak_pc", bus.PC, 32'h10);
      step(0, 0, 0, 32'h0, 0);
      check("halt_bubble", 32'(bus.if_id_valid), 32'd0);
      check("halt_pc", bus.PC, 32'h10);
      step(0, 0, 0, 32'h0, 1);
      check("resume_pc", bus.PC, 32'h14);
      check("resume_halted", 32'(bus.halted), 32'd0);
      step(0, 0, 0, 32'h0, 0);

      step(0, 0, 1, 32'hFFFF_FFFC, 0);
      step(0, 0, 0, 32'h0, 0);
      check("wrap_pc", bus.PC, 32'h0);
      check("wrap_pc4", bus.if_id_pc_plus4, 32'h0);

      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_pc", bus.PC, 32'h0);
      check("async_rst_valid", 32'(bus.if_id_valid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
